fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the architectural PC and sequences instruction-memory reads for the RV32I core.
- Feeds the decode/immediate stage one instruction at a time through a valid/ready handshake.
- Accepts redirects (SB/UJ branch/jump targets and JALR targets) from execute.
- Guarantees exactly one outstanding memory request at a time and discards stale responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid; held until granted.
- imem_addr  out  XLEN  word-aligned fetch address; stable while imem_req is high.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after imem_gnt.
- imem_rdata  in  XLEN  instruction word.
- instr_valid  out  1  instr_out and pc_out hold a valid instruction.
- instr_ready  in  1  downstream consumes the instruction this cycle.
- instr_out  out  XLEN  fetched instruction.
- pc_out  out  XLEN  address of instr_out.
- redirect_valid  in  1  change flow this cycle.
- redirect_pc  in  XLEN  new PC (branch/jump/JALR target).
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] was non-zero.
- fetch_cnt  out  XLEN  count of instructions handed off; wraps modulo 2^32.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state=REQ, pc=RESET_PC, drop=0.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr_out=32'h0000_0013 (NOP), pc_out=0.
  - misalign_err=0, fetch_cnt=0.
- imem_req is registered, so it first asserts in the first clock after rst_n deasserts.
- States:
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT.
  - WAIT: imem_req=0; waiting for imem_rvalid.
  - HOLD: instr_valid=1 until instr_ready.
- WAIT, imem_rvalid, drop=0:
  - Register instr_out=imem_rdata and pc_out=pc.
  - Go to HOLD; instr_valid rises the next cycle.
  - Latency from grant: rvalid at cycle N gives instr_valid at N+1.
- WAIT, imem_rvalid, drop=1: discard the data, clear drop, go to REQ (pc already holds the redirect target).
- HOLD with instr_ready and no redirect:
  - pc <= pc+4, wrapping 32'hFFFF_FFFC to 0.
  - fetch_cnt += 1.
  - instr_valid falls; go to REQ.
- A consumed instruction occupies at least 3 cycles per fetch (REQ→WAIT→HOLD minimum); no prefetch.
- Redirect: the effective target is {redirect_pc[31:2],2'b00}. If redirect_pc[1:0]!=0, misalign_err pulses the next cycle. Redirect has priority over every other event in the same cycle:
  - REQ, no gnt: pc <= target, stay in REQ; the new address is presented next cycle.
  - REQ with gnt in the same cycle: the granted request used the old pc. Set pc <= target, drop=1, go to WAIT.
  - WAIT, no rvalid: pc <= target, drop=1.
  - WAIT with rvalid in the same cycle: discard the data, pc <= target, go to REQ; drop stays 0.
  - HOLD (with or without instr_ready): discard the held instruction, instr_valid=0 next cycle, fetch_cnt unchanged, pc <= target, go to REQ.
- A repeated redirect while drop=1 only updates pc. At most one response is ever dropped.
- Invariant: instr_out and pc_out never change while instr_valid=1 and instr_ready=0.
- Reset mid-transaction: everything returns to reset values immediately. A late imem_rvalid arriving in REQ state is ignored.

Decomposition:
- Shared package rv32_pkg:
  - fetch_state_t enum {REQ, WAIT, HOLD}.
  - RESET_PC_DEFAULT.
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 4.
- One natural sub-module, pc_next_sel:
  - Combinational next-PC select among hold, pc+4 and aligned redirect target.
  - Also produces the misalignment flag.
- The FSM, drop flag and output registers stay in fetch_sequencer.

Test Plan:
- Reset then stream, memory with gnt=1 and rvalid 1 cycle later, ready=1:
  - imem_addr goes 0x0, 0x4, 0x8.
  - pc_out matches each address; fetch_cnt reaches 3.
  - instr_valid rises 1 cycle after each rvalid.
- Backpressure: ready=0 for 5 cycles in HOLD with rdata=0x00500093 → instr_out and pc_out stable, no new imem_req, fetch_cnt unchanged.
- Redirect during WAIT: redirect_pc=0x100 while a request for 0x8 is outstanding → the 0x8 response is dropped, the next imem_addr is 0x100, and instr_valid never shows pc_out=0x8.
- Redirect coincident with gnt in REQ (pc=0x4, target 0x200) → the response is dropped, then a request to 0x200 issues; exactly one drop occurs.
- Misaligned redirect 0x0000_0102 in HOLD → misalign_err pulses once, the next fetch is at 0x100, and the held instruction is discarded.
- Wrap and reset: pc=0xFFFF_FFFC consumed → next imem_addr=0x0. Asserting rst_n=0 while in WAIT → imem_req=0 and instr_valid=0 immediately; after release the first fetch is at RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32I front end.
package rv32_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Next-PC select: hold, sequential step, or word-aligned redirect target.
module pc_next_sel
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_advance,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_misalign
);

  always_comb begin
    o_pc_next  = i_pc;
    o_misalign = 1'b0;
    // Redirect outranks the sequential step; low bits are forced to zero.
    if (i_redirect_valid) begin
      o_pc_next  = {i_redirect_pc[XLEN-1:2], 2'b00};
      o_misalign = (i_redirect_pc[1:0] != 2'b00);
    end else if (i_advance) begin
      o_pc_next  = i_pc + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem read at a time,
// hands instructions downstream via valid/ready, and absorbs redirects.
module fetch_sequencer
  import rv32_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_cnt
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic            r_drop;
  logic            w_drop_next;
  logic            r_req;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_out;
  logic            r_misalign;
  logic [XLEN-1:0] r_cnt;
  logic            w_capture;
  logic            w_advance;
  logic [XLEN-1:0] w_pc_next;
  logic            w_misalign;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .i_pc             (r_pc),
    .i_advance        (w_advance),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_pc_next        (w_pc_next),
    .o_misalign       (w_misalign)
  );

  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    unique case (r_state)
      REQ: begin
        // A grant alongside a redirect fetched the old PC; its reply is stale.
        if (r_req && imem_gnt) begin
          w_state_next = WAIT;
          if (redirect_valid) w_drop_next = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_drop_next = 1'b0;
          if (redirect_valid || r_drop) begin
            w_state_next = REQ;
          end else begin
            w_capture    = 1'b1;
            w_state_next = HOLD;
          end
        end else if (redirect_valid) begin
          w_drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_state_next = REQ;
        end else if (instr_ready) begin
          w_advance    = 1'b1;
          w_state_next = REQ;
        end
      end
      default: w_state_next = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_req      <= 1'b0;
      r_instr    <= XLEN'(NOP_INSTR);
      r_pc_out   <= '0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_drop     <= w_drop_next;
      r_req      <= (w_state_next == REQ);
      r_misalign <= w_misalign;
      if (w_capture) begin
        r_instr  <= imem_rdata;
        r_pc_out <= r_pc;
      end
      if (w_advance) r_cnt <= r_cnt + XLEN'(1);
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_pc;
  assign instr_valid  = (r_state == HOLD);
  assign instr_out    = r_instr;
  assign pc_out       = r_pc_out;
  assign misalign_err = r_misalign;
  assign fetch_cnt    = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural memory plus a transaction-level
// model of the architectural PC, handoff count and held instruction.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] exp_pc, exp_cnt, exp_instr, exp_hold_pc;
  logic        exp_valid, exp_mis;
  logic        pend, pend_stale;
  int          pend_dly;
  logic [31:0] pend_addr;
  logic        ovr_en = 1'b0;
  logic [31:0] data_ovr = 32'h0;
  logic        inj_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc    = 32'h0;
    exp_cnt   = 32'h0;
    exp_valid = 1'b0;
    exp_mis   = 1'b0;
    exp_instr = 32'h0000_0013;
    exp_hold_pc = 32'h0;
    pend      = 1'b0;
    pend_stale = 1'b0;
    pend_dly  = 0;
    pend_addr = 32'h0;
  endtask

  // One clock: drive at the falling edge, update the model, check after the rising edge.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc,
                      input int gnt_pct, input int dlo, input int dhi);
    logic        gnt_now, rv_now, good_rv;
    logic [31:0] rd;
    gnt_now = imem_req && ($urandom_range(99) < gnt_pct);
    rv_now  = 1'b0;
    rd      = ovr_en ? data_ovr : $urandom;
    if (pend) begin
      if (pend_dly == 0) rv_now = 1'b1;
      else pend_dly--;
    end
    if (inj_rv && !pend) rv_now = 1'b1;
    imem_gnt       = gnt_now;
    imem_rvalid    = rv_now;
    imem_rdata     = rd;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;

    good_rv = rv_now && pend && !pend_stale && !redir;
    if (exp_valid && rdy && !redir) begin
      exp_pc    = exp_pc + 32'd4;
      exp_cnt   = exp_cnt + 32'd1;
      exp_valid = 1'b0;
    end
    if (redir) begin
      exp_pc    = {rpc[31:2], 2'b00};
      exp_valid = 1'b0;
    end
    if (rv_now && pend) pend = 1'b0;
    if (good_rv) begin
      exp_valid   = 1'b1;
      exp_instr   = rd;
      exp_hold_pc = pend_addr;
    end
    if (pend && redir) pend_stale = 1'b1;
    if (gnt_now) begin
      pend       = 1'b1;
      pend_stale = redir;
      pend_addr  = imem_addr;
      pend_dly   = dlo + $urandom_range(dhi - dlo);
    end
    exp_mis = redir && (rpc[1:0] != 2'b00);

    @(posedge clk);
    @(negedge clk);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    chk("imem_req", {31'b0, imem_req}, {31'b0, !exp_valid && !pend});
    chk("fetch_cnt", fetch_cnt, exp_cnt);
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
    if (exp_valid) begin
      chk("instr_out", instr_out, exp_instr);
      chk("pc_out", pc_out, exp_hold_pc);
    end
    if (imem_req) chk("imem_addr", imem_addr, exp_pc);
  endtask

  task automatic drive_idle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
  endtask

  initial begin
    logic [31:0] tgt;
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    rst_n = 1'b1;

    // Streaming: always-grant, single-cycle response, always ready.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 100, 0, 0);
    chk("stream_cnt", fetch_cnt, 32'd3);

    // Backpressure with a fixed instruction word.
    ovr_en = 1'b1; data_ovr = 32'h0050_0093;
    for (int i = 0; i < 20 && !exp_valid; i++) step(1'b0, 1'b0, 32'h0, 100, 0, 0);
    chk("bp_reach", {31'b0, instr_valid}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 100, 0, 0);
    chk("bp_instr", instr_out, 32'h0050_0093);
    step(1'b1, 1'b0, 32'h0, 100, 0, 0);
    ovr_en = 1'b0;

    // Redirect while a request is outstanding.
    for (int i = 0; i < 20 && !pend; i++) step(1'b1, 1'b0, 32'h0, 100, 3, 3);
    step(1'b1, 1'b1, 32'h100, 100, 3, 3);
    for (int i = 0; i < 30 && !exp_valid; i++) step(1'b0, 1'b0, 32'h0, 100, 0, 1);
    chk("wait_redir_pc", pc_out, 32'h100);
    step(1'b1, 1'b0, 32'h0, 0, 0, 0);

    // Redirect in the same cycle as a grant.
    for (int i = 0; i < 20 && !imem_req; i++) step(1'b1, 1'b0, 32'h0, 0, 0, 0);
    step(1'b1, 1'b1, 32'h200, 100, 1, 1);
    for (int i = 0; i < 30 && !exp_valid; i++) step(1'b0, 1'b0, 32'h0, 100, 0, 1);
    chk("gnt_redir_pc", pc_out, 32'h200);

    // Misaligned redirect while holding.
    step(1'b1, 1'b1, 32'h0000_0102, 100, 0, 0);
    for (int i = 0; i < 30 && !exp_valid; i++) step(1'b0, 1'b0, 32'h0, 100, 0, 1);
    chk("mis_redir_pc", pc_out, 32'h100);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 100, 0, 0);
    for (int i = 0; i < 30 && !exp_valid; i++) step(1'b0, 1'b0, 32'h0, 100, 0, 1);
    chk("wrap_hold_pc", pc_out, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while a response is outstanding, then a late response.
    for (int i = 0; i < 20 && !pend; i++) step(1'b1, 1'b0, 32'h0, 100, 4, 4);
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req", {31'b0, imem_req}, 32'd0);
    chk("rst_wait_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_wait_cnt", fetch_cnt, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    inj_rv = 1'b1;
    step(1'b1, 1'b0, 32'h0, 0, 0, 0);
    inj_rv = 1'b0;
    step(1'b1, 1'b0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 30 && !exp_valid; i++) step(1'b0, 1'b0, 32'h0, 100, 0, 1);
    chk("post_rst_pc", pc_out, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : {20'h0, 12'($urandom)};
      step(1'($urandom_range(1)), ($urandom_range(99) < 6), tgt, 70, 0, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
